// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_e;

  function automatic logic is_mul(muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_signed_a(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiply or restoring divide on {hi, lo}.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_mul,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] sh;
  logic [XLEN+1:0]   diff;
  logic              unused_diff_msb;

  // The shifted-out top bit joins the partial remainder so it never truncates.
  assign sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign sh   = {acc[2*XLEN-2:0], 1'b0};
  assign diff = {1'b0, acc[2*XLEN-1], sh[2*XLEN-1:XLEN]} - {2'b00, opnd};
  assign unused_diff_msb = diff[XLEN];

  always_comb begin
    acc_nxt = sh;
    if (is_mul)
      acc_nxt = {sum, acc[XLEN-1:1]};
    else if (!diff[XLEN+1])
      acc_nxt = {diff[XLEN-1:0], sh[XLEN-1:1], 1'b1};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M controller: 32 shift-add/subtract iterations plus a sign-fix step.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_in;
  logic [4:0]        cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_nxt, prod_fix;
  logic [XLEN-1:0]   opnd_q, mag_a, mag_b, quo_fix, rem_fix, fix_res, fast_res;
  logic              sa_q, sb_q, sgn_a, sgn_b;
  logic              accept, div_zero, div_ovf, fast;

  assign op_in  = muldiv_op_e'(op);
  assign accept = (state_q == IDLE) && start && !flush;
  assign sgn_a  = is_signed_a(op_in) & rs1[XLEN-1];
  assign sgn_b  = is_signed_b(op_in) & rs2[XLEN-1];
  assign mag_a  = sgn_a ? -rs1 : rs1;
  assign mag_b  = sgn_b ? -rs2 : rs2;

  // Division corner cases resolve without iterating.
  assign div_zero = !is_mul(op_in) && (rs2 == '0);
  assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
                    (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign fast     = div_zero || div_ovf;

  always_comb begin
    fast_res = '0;
    if (div_zero)
      fast_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : rs1;
    else if (op_in == OP_DIV)
      fast_res = rs1;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_mul  (is_mul(op_q)),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_nxt)
  );

  // Quotient sign follows the operand signs; remainder follows the dividend.
  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = rem_fix;
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = fast ? DONE : CALC;
      CALC: if (cnt_q == 5'(ITER-1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MUL;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          op_q   <= op_in;
          sa_q   <= sgn_a;
          sb_q   <= sgn_b;
          cnt_q  <= '0;
          acc_q  <= is_mul(op_in) ? {{XLEN{1'b0}}, mag_b} : {{XLEN{1'b0}}, mag_a};
          opnd_q <= is_mul(op_in) ? mag_a : mag_b;
          if (fast) begin
            result <= fast_res;
            done   <= 1'b1;
          end
        end
        CALC: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 5'd1;
        end
        FIX: if (!flush) begin
          result <= fix_res;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign stall = accept || (state_q == CALC) || (state_q == FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + random scoreboard bench for muldiv_sequencer.
module tb_muldiv_sequencer;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0, result;
  logic        stall, busy, done;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] sb_q[$];

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drives one op, waits (bounded) for done, checks latency, result and stall profile.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input bit chk_stall,
                        input bit disturb);
    int lat;
    logic [31:0] exp;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    sb_q.push_back(model(o, a, b));
    #1 if (chk_stall) chk({tag, " stall c0"}, 32'(stall), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = disturb && (lat >= 5) && (lat < 8);
      if (disturb && lat == 5) begin op = ~o; rs1 = ~a; rs2 = b + 32'd1; end
      #1 if (chk_stall && !done) chk({tag, " stall busy"}, 32'(stall), 32'd1);
    end while (!done && lat < 100);
    chk({tag, " done seen"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " stall done"}, 32'(stall), 32'd0);
    if (sb_q.size() == 0) chk({tag, " scoreboard"}, 32'd0, 32'd1);
    else begin
      exp = sb_q.pop_front();
      chk({tag, " result"}, result, exp);
    end
    @(negedge clk);
    #1 chk({tag, " idle after"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    bit seen_done;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          elat;

    #1;
    chk("reset outs", {29'b0, stall, busy, done}, 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("MUL 7*-3",     3'd0, 32'd7,          32'hFFFF_FFFD, 34, 1'b1, 1'b0);
    run_op("MULH min*min", 3'd1, 32'h8000_0000,  32'h8000_0000, 34, 1'b0, 1'b0);
    run_op("MULHU max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 1'b0, 1'b0);
    run_op("MULHSU -1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 1'b0, 1'b0);
    run_op("DIV -7/2",     3'd4, 32'hFFFF_FFF9,  32'd2,         34, 1'b0, 1'b0);
    run_op("REM -7/2",     3'd6, 32'hFFFF_FFF9,  32'd2,         34, 1'b0, 1'b0);
    run_op("DIVU 100/7",   3'd5, 32'd100,        32'd7,         34, 1'b0, 1'b0);
    run_op("REMU 100/7",   3'd7, 32'd100,        32'd7,         34, 1'b0, 1'b0);
    run_op("DIVU wide",    3'd5, 32'hFFFF_FFFF,  32'h8000_0001, 34, 1'b0, 1'b0);
    run_op("REMU wide",    3'd7, 32'hFFFF_FFFF,  32'h8000_0001, 34, 1'b0, 1'b0);
    run_op("DIVU by0",     3'd5, 32'h0000_1234,  32'd0,         1,  1'b1, 1'b0);
    run_op("REMU by0",     3'd7, 32'h0000_1234,  32'd0,         1,  1'b0, 1'b0);
    run_op("DIV ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 1,  1'b0, 1'b0);
    run_op("REM ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 1,  1'b0, 1'b0);

    // Flush mid-divide: no done, back to IDLE one edge later.
    @(negedge clk);
    op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    seen_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1 if (done) seen_done = 1'b1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 if (done) seen_done = 1'b1;
    chk("flush no done", 32'(seen_done), 32'd0);
    chk("flush idle", {30'b0, busy, stall}, 32'd0);
    run_op("MUL 3*5 post flush", 3'd0, 32'd3, 32'd5, 34, 1'b1, 1'b0);

    // start while busy and rs1 changes mid-op must not disturb the result.
    run_op("MUL disturbed", 3'd0, 32'h0000_1111, 32'h0000_0022, 34, 1'b0, 1'b1);
    run_op("DIV disturbed", 3'd4, 32'hFFFF_F000, 32'd7,         34, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 20));
      if (i == 7) rb = 32'd0;
      elat = (ro[2] && ((rb == 0) ||
             ((ro == 3'd4 || ro == 3'd6) && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))) ? 1 : 34;
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, elat, 1'b0, 1'b0);
    end

    // Async reset at cycle 20 of a multiply clears everything at once.
    @(negedge clk);
    op = 3'd0; rs1 = 32'h1234; rs2 = 32'h10; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset mid outs", {29'b0, stall, busy, done}, 32'd0);
    chk("reset mid result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("MULHU after reset", 3'd3, 32'h0001_0000, 32'h0003_0000, 34, 1'b0, 1'b0);

    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller for the RV32M multiply/divide instructions in the execute stage. It accepts one operation from the EX stage and stalls the pipeline while it computes: 32 iterations of a shift-add multiply or a restoring divide, then one sign-fix step. It returns a 32-bit result alongside the single-cycle ALU result, which the EX result mux selects.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  EX holds an M-extension operation; sampled only in IDLE.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`  in  XLEN  operand A (multiplicand or dividend).
- `rs2`  in  XLEN  operand B (multiplier or divisor).
- `flush`  in  1  squashes the in-flight operation.
- `stall`  out  1  holds the IF/ID/EX pipeline registers.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  operation result.

## Operation
- States and transitions:
  - IDLE: on `start` and not `flush`, go to CALC, or to DONE on the fast path.
  - CALC: runs exactly 32 cycles, then goes to FIX.
  - FIX: one cycle, then DONE.
  - DONE: one cycle, then IDLE.
- On acceptance, latch `op`. Convert each operand to a magnitude if it is treated as signed:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: `rs1` signed only.
  - All other ops: unsigned.
- Record the operand signs. Clear the 64-bit accumulator and the 5-bit iteration counter.
- Multiply, per CALC cycle: if the multiplier LSB is 1, add the multiplicand to the upper half; then shift the 64-bit {acc, multiplier} right by 1, keeping the 33-bit carry.
- Divide, per CALC cycle: shift {rem, quotient} left by 1; trial-subtract the divisor from rem; if the difference is non-negative, keep it and set the quotient LSB.
- FIX:
  - Negate the product if the signs differ.
  - Negate the quotient if the signs differ.
  - The remainder takes the dividend's sign.
- Result select: MUL takes low 32 bits; MULH/MULHSU/MULHU take high 32 bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
- Fast path from IDLE straight to DONE (no CALC):
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `rs1`.
  - Signed overflow, DIV/REM with `rs1`=0x80000000 and `rs2`=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- `flush` in any state returns to IDLE at the next edge, with no `done`. `flush` and `start` together in IDLE: the operation is not accepted.
- `start` outside IDLE is ignored. An operation is accepted again only from IDLE, so no back-to-back acceptance in DONE.
- Operands are latched at acceptance. Later changes on `rs1`/`rs2` have no effect.

## Timing
- Reset, asynchronous: state IDLE, counter 0, accumulator 0, `result`=0, `done`=0, `busy`=0, `stall`=0. Reset mid-operation abandons the operation immediately.
- `stall` is combinational: high when (IDLE and `start` and not `flush`), or when in CALC or FIX. It is low in DONE so EX advances and captures `result`.
- `result` and `done` are registered and come from state DONE.
- Normal latency, with `start` sampled at edge 0:
  - CALC occupies cycles 1–32.
  - FIX is cycle 33.
  - `done` is high in cycle 34.
  - IDLE again in cycle 35.
  - Total 34 cycles, independent of operand values.
- Fast path: `done` is high in cycle 1.
- `result` holds its last value after DONE until the next DONE or reset.

## Structure
- Package `muldiv_pkg` holds:
  - the `muldiv_op_e` enum (the 8 funct3 codes) and the `is_mul`/`is_signed_a`/`is_signed_b` helper functions;
  - the `muldiv_state_e` enum {IDLE, CALC, FIX, DONE};
  - localparam `ITER = 32`.
- One sub-module: `muldiv_step`, the combinational single-iteration datapath (add-shift or subtract-shift, chosen by `is_mul`). The FSM, counter and registers stay in `muldiv_sequencer`.
- The EX-stage ALU is unchanged. The result mux and stall OR-ing happen at the stage level.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result`=0xFFFFFFEB; `done` exactly 34 cycles after `start`; `stall` high cycles 0–33, low in 34.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 0x1234 / 0 → 0xFFFFFFFF, and REMU 0x1234 / 0 → 0x1234, each with `done` in cycle 1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0; each with `done` in cycle 1.
- `flush` at cycle 10 of a DIV → IDLE at cycle 11, no `done`, `stall` low. A new MUL 3×5 then returns 15 with `done` at its own cycle 34.
- `rst_n` low at cycle 20 of a MUL → all outputs 0 immediately. `start` while busy, or `rs1` changed mid-operation → no effect on the result.
